// File: rtl/alu_pkg.sv
// Shared constants for the ALU: default datapath width and operation codes.
// The divider is compiled in only when ALU_DIV_EN is defined.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOTA = 4'd7;
  localparam logic [3:0] OP_NOTB = 4'd8;

endpackage

// File: rtl/alu_div.sv
// Unsigned combinational restoring divider producing a quotient and a
// divide-by-zero indication; the remainder is carried only internally.
module alu_div
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             div_by_zero
);

  logic [WIDTH-1:0] rem_s;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH-1:0] quot_s;

  // One restoring step per dividend bit, MSB first.
  always_comb begin
    rem_s     = {WIDTH{1'b0}};
    shifted_s = {(WIDTH+1){1'b0}};
    quot_s    = {WIDTH{1'b0}};
    for (int i = WIDTH - 1; i >= 0; i--) begin
      shifted_s = {rem_s, dividend[i]};
      if (shifted_s >= {1'b0, divisor}) begin
        rem_s     = WIDTH'(shifted_s - {1'b0, divisor});
        quot_s[i] = 1'b1;
      end else begin
        rem_s     = shifted_s[WIDTH-1:0];
        quot_s[i] = 1'b0;
      end
    end
  end

  assign quotient    = quot_s;
  assign div_by_zero = (divisor == {WIDTH{1'b0}});

endmodule

// File: rtl/alu.sv
// Single-cycle registered ALU (add/sub/mul/optional div/logic ops).
// Define ALU_DIV_EN to compile in the divider for fn_sel 3.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       fn_sel,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] data_out,
  output logic             zero_flag,
  output logic             carry_flag
);

  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   result_s;
  logic               carry_s;

  assign sum_s  = {1'b0, data_a} + {1'b0, data_b};
  assign prod_s = {{WIDTH{1'b0}}, data_a} * {{WIDTH{1'b0}}, data_b};

`ifdef ALU_DIV_EN
  logic [WIDTH-1:0] quot_s;
  logic             div_zero_s;

  alu_div #(.WIDTH(WIDTH)) u_div (
    .dividend    (data_a),
    .divisor     (data_b),
    .quotient    (quot_s),
    .div_by_zero (div_zero_s)
  );
`endif

  // Operation decode; unused codes fall through to a zero result.
  always_comb begin
    result_s = {WIDTH{1'b0}};
    carry_s  = 1'b0;
    case (fn_sel)
      OP_ADD: begin
        result_s = sum_s[WIDTH-1:0];
        carry_s  = sum_s[WIDTH];
      end
      OP_SUB: begin
        result_s = data_a - data_b;
        carry_s  = (data_a < data_b);
      end
      OP_MUL: begin
        result_s = prod_s[WIDTH-1:0];
        carry_s  = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
      end
`ifdef ALU_DIV_EN
      OP_DIV: begin
        if (div_zero_s) begin
          result_s = {WIDTH{1'b1}};
          carry_s  = 1'b1;
        end else begin
          result_s = quot_s;
          carry_s  = 1'b0;
        end
      end
`endif
      OP_AND:  result_s = data_a & data_b;
      OP_OR:   result_s = data_a | data_b;
      OP_XOR:  result_s = data_a ^ data_b;
      OP_NOTA: result_s = ~data_a;
      OP_NOTB: result_s = ~data_b;
      default: begin
        result_s = {WIDTH{1'b0}};
        carry_s  = 1'b0;
      end
    endcase
  end

  // Output registers; zero_flag is derived from the same value loaded into data_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= {WIDTH{1'b0}};
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else begin
      data_out   <= result_s;
      zero_flag  <= (result_s == {WIDTH{1'b0}});
      carry_flag <= carry_s;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu; DIV expectations follow ALU_DIV_EN.
module tb_alu;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  fn_sel;
  logic [15:0] data_a;
  logic [15:0] data_b;
  logic [15:0] data_out;
  logic        zero_flag;
  logic        carry_flag;

  int total = 0;
  int bad   = 0;

  alu #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .fn_sel     (fn_sel),
    .data_a     (data_a),
    .data_b     (data_b),
    .data_out   (data_out),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] fn, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] ed, input logic ec,
                        input logic ez);
    @(negedge clk);
    fn_sel = fn;
    data_a = a;
    data_b = b;
    @(posedge clk);
    #1;
    check({tag, ".data"},  data_out, ed);
    check({tag, ".carry"}, {15'd0, carry_flag}, {15'd0, ec});
    check({tag, ".zero"},  {15'd0, zero_flag},  {15'd0, ez});
  endtask

  initial begin
    rst    = 1'b1;
    fn_sel = OP_ADD;
    data_a = 16'hFFFF;
    data_b = 16'h0001;
    repeat (2) @(posedge clk);
    #1;
    check("reset.data",  data_out, 16'h0000);
    check("reset.carry", {15'd0, carry_flag}, 16'h0000);
    check("reset.zero",  {15'd0, zero_flag},  16'h0000);
    @(negedge clk);
    rst = 1'b0;

    run_op("add_wrap",  OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1);
    run_op("add_plain", OP_ADD, 16'h2001, 16'h0001, 16'h2002, 1'b0, 1'b0);
    run_op("sub_borrow",OP_SUB, 16'h0002, 16'h0003, 16'hFFFF, 1'b1, 1'b0);
    run_op("sub_zero",  OP_SUB, 16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b1);
    run_op("mul_ovf",   OP_MUL, 16'h8001, 16'h0003, 16'h8003, 1'b1, 1'b0);
    run_op("mul_zero",  OP_MUL, 16'h0003, 16'h0000, 16'h0000, 1'b0, 1'b1);
    run_op("mul_fit",   OP_MUL, 16'h00FF, 16'h0100, 16'hFF00, 1'b0, 1'b0);
`ifdef ALU_DIV_EN
    run_op("div_by0",   OP_DIV, 16'h0001, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
    run_op("div_9_4",   OP_DIV, 16'h0009, 16'h0004, 16'h0002, 1'b0, 1'b0);
    run_op("div_3_2",   OP_DIV, 16'h0003, 16'h0002, 16'h0001, 1'b0, 1'b0);
    run_op("div_max",   OP_DIV, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 1'b0);
    run_op("div_small", OP_DIV, 16'h0005, 16'h0007, 16'h0000, 1'b0, 1'b1);
    run_op("div_big",   OP_DIV, 16'hFFFE, 16'h00FF, 16'h0100, 1'b0, 1'b0);
`else
    run_op("div_off0",  OP_DIV, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b1);
    run_op("div_off1",  OP_DIV, 16'h0009, 16'h0004, 16'h0000, 1'b0, 1'b1);
`endif
    run_op("and",       OP_AND,  16'h8001, 16'h8001, 16'h8001, 1'b0, 1'b0);
    run_op("or",        OP_OR,   16'h0F00, 16'h00F0, 16'h0FF0, 1'b0, 1'b0);
    run_op("xor_zero",  OP_XOR,  16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1);
    run_op("xor_mix",   OP_XOR,  16'hA5A5, 16'h0FF0, 16'hAA55, 1'b0, 1'b0);
    run_op("nota",      OP_NOTA, 16'hE001, 16'h1234, 16'h1FFE, 1'b0, 1'b0);
    run_op("notb",      OP_NOTB, 16'h1234, 16'hE001, 16'h1FFE, 1'b0, 1'b0);
    run_op("nota_zero", OP_NOTA, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b1);
    run_op("unused9",   4'd9,    16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1);
    run_op("unused15",  4'd15,   16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1);

    // Reset mid-stream after a MUL that sets carry, then recover.
    run_op("pre_rst",   OP_MUL, 16'h8001, 16'h0003, 16'h8003, 1'b1, 1'b0);
    @(negedge clk);
    rst    = 1'b1;
    fn_sel = OP_MUL;
    data_a = 16'hFFFF;
    data_b = 16'hFFFF;
    @(posedge clk);
    #1;
    check("midrst.data",  data_out, 16'h0000);
    check("midrst.carry", {15'd0, carry_flag}, 16'h0000);
    check("midrst.zero",  {15'd0, zero_flag},  16'h0000);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst",  OP_ADD, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
